// File: rtl/demux_1to4_reg.sv
// demux_1to4_reg: write-side 1-to-4 demultiplexer into four holding registers.
// Each register has a valid flag. A clear sweep resets the registers one per
// cycle in the order a, b, c, d. While the sweep runs, busy is high and writes
// are refused. All outputs are taken directly from flops.
module demux_1to4_reg #(
  parameter int unsigned    WIDTH     = 4,
  parameter logic [31:0]    RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       sel,
  input  logic             wr_en,
  input  logic             clr,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [3:0]       valid,
  output logic             busy,
  output logic             wr_ready
);

  // Reset/clear value. It is zero-extended or truncated to the register width.
  localparam logic [WIDTH-1:0] L_RST = WIDTH'(RESET_VAL);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [WIDTH-1:0] r_reg [4];
  logic [3:0]       r_valid;
  logic             r_busy;

  // FSM with registered outputs. IDLE accepts clr (which has priority) or a
  // write. CLEAR wipes one register per edge and ignores every request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_busy  <= 1'b0;
      r_valid <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        r_reg[i] <= L_RST;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clr) begin
            r_state <= S_CLEAR;
            r_idx   <= 2'd0;
            r_busy  <= 1'b1;
          end else if (wr_en) begin
            r_reg[sel]   <= in;
            r_valid[sel] <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_reg[r_idx]   <= L_RST;
          r_valid[r_idx] <= 1'b0;
          r_idx          <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a        = r_reg[0];
  assign b        = r_reg[1];
  assign c        = r_reg[2];
  assign d        = r_reg[3];
  assign valid    = r_valid;
  assign busy     = r_busy;
  assign wr_ready = ~r_busy;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Testbench for demux_1to4_reg. It has four parts:
// 1. A table of per-cycle vectors.
// 2. Hand-written sequences for asynchronous reset.
// 3. A randomized run checked against a behavioural model.
// 4. A summary line at the end.
module tb_demux_1to4_reg;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic [W-1:0] t_in;
  logic [1:0]   t_sel;
  logic         t_wr;
  logic         t_clr;
  logic [W-1:0] t_a, t_b, t_c, t_d;
  logic [3:0]   t_valid;
  logic         t_busy;
  logic         t_wr_ready;

  int n_cmp;
  int n_fail;

  demux_1to4_reg #(.WIDTH(W), .RESET_VAL(32'd0)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (t_in),
    .sel      (t_sel),
    .wr_en    (t_wr),
    .clr      (t_clr),
    .a        (t_a),
    .b        (t_b),
    .c        (t_c),
    .d        (t_d),
    .valid    (t_valid),
    .busy     (t_busy),
    .wr_ready (t_wr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model.
  // sweep_left is the number of clearing edges still to come (0 means idle).
  // The register cleared on a given edge is number 4 - sweep_left.
  int m_reg [4];
  bit m_val [4];
  int sweep_left;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_reg[i] = 0;
      m_val[i] = 1'b0;
    end
    sweep_left = 0;
  endfunction

  function automatic void model_step();
    if (reset) begin
      model_reset();
    end else if (sweep_left > 0) begin
      m_reg[4 - sweep_left] = 0;
      m_val[4 - sweep_left] = 1'b0;
      sweep_left--;
    end else if (t_clr) begin
      sweep_left = 4;
    end else if (t_wr) begin
      m_reg[t_sel] = int'(t_in);
      m_val[t_sel] = 1'b1;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ea, input int eb, input int ec,
                         input int ed, input int ev, input int ebusy);
    chk({tag, ".a"}, int'(t_a), ea);
    chk({tag, ".b"}, int'(t_b), eb);
    chk({tag, ".c"}, int'(t_c), ec);
    chk({tag, ".d"}, int'(t_d), ed);
    chk({tag, ".valid"}, int'(t_valid), ev);
    chk({tag, ".busy"}, int'(t_busy), ebusy);
    chk({tag, ".wr_ready"}, int'(t_wr_ready), 1 - ebusy);
  endtask

  // Advance one clock edge. The model steps on the same edge, and the outputs
  // are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic wr, input logic cl, input logic [1:0] s,
                       input logic [W-1:0] v);
    t_wr  = wr;
    t_clr = cl;
    t_sel = s;
    t_in  = v;
  endtask

  typedef struct packed {
    logic       wr;
    logic       clr;
    logic [1:0] sel;
    logic [3:0] din;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [3:0] ec;
    logic [3:0] ed;
    logic [3:0] ev;
    logic       ebusy;
  } vec_t;

  localparam int NVEC = 32;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic wr, input logic cl, input logic [1:0] s,
                              input logic [3:0] v, input logic [3:0] ea,
                              input logic [3:0] eb, input logic [3:0] ec,
                              input logic [3:0] ed, input logic [3:0] ev,
                              input logic eby);
    vec_t r;
    r.wr = wr; r.clr = cl; r.sel = s; r.din = v;
    r.ea = ea; r.eb = eb; r.ec = ec; r.ed = ed; r.ev = ev; r.ebusy = eby;
    return r;
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    model_reset();

    // Each entry: inputs applied for one edge, then the outputs expected after it.
    //              wr clr sel  in    a     b     c     d     valid    busy
    vecs[0]  = mk(1, 0, 2'd0, 4'h3, 4'h3, 4'h0, 4'h0, 4'h0, 4'b0001, 0);
    vecs[1]  = mk(1, 0, 2'd1, 4'hA, 4'h3, 4'hA, 4'h0, 4'h0, 4'b0011, 0);
    vecs[2]  = mk(1, 0, 2'd2, 4'h5, 4'h3, 4'hA, 4'h5, 4'h0, 4'b0111, 0);
    vecs[3]  = mk(1, 0, 2'd3, 4'hF, 4'h3, 4'hA, 4'h5, 4'hF, 4'b1111, 0);
    vecs[4]  = mk(0, 0, 2'd1, 4'h6, 4'h3, 4'hA, 4'h5, 4'hF, 4'b1111, 0);
    vecs[5]  = mk(0, 0, 2'd2, 4'h7, 4'h3, 4'hA, 4'h5, 4'hF, 4'b1111, 0);
    vecs[6]  = mk(0, 0, 2'd3, 4'h8, 4'h3, 4'hA, 4'h5, 4'hF, 4'b1111, 0);
    vecs[7]  = mk(1, 0, 2'd2, 4'h9, 4'h3, 4'hA, 4'h9, 4'hF, 4'b1111, 0);
    vecs[8]  = mk(1, 0, 2'd2, 4'h5, 4'h3, 4'hA, 4'h5, 4'hF, 4'b1111, 0);
    // Clear sweep. A write to d held during the sweep must be dropped.
    vecs[9]  = mk(0, 1, 2'd0, 4'h0, 4'h3, 4'hA, 4'h5, 4'hF, 4'b1111, 1);
    vecs[10] = mk(1, 0, 2'd3, 4'h7, 4'h0, 4'hA, 4'h5, 4'hF, 4'b1110, 1);
    vecs[11] = mk(1, 0, 2'd3, 4'h7, 4'h0, 4'h0, 4'h5, 4'hF, 4'b1100, 1);
    vecs[12] = mk(1, 0, 2'd3, 4'h7, 4'h0, 4'h0, 4'h0, 4'hF, 4'b1000, 1);
    vecs[13] = mk(1, 0, 2'd3, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0);
    vecs[14] = mk(1, 0, 2'd3, 4'h7, 4'h0, 4'h0, 4'h0, 4'h7, 4'b1000, 0);
    // Collision: clr wins and b never receives C. A repeated clr does not restart the sweep.
    vecs[15] = mk(1, 1, 2'd1, 4'hC, 4'h0, 4'h0, 4'h0, 4'h7, 4'b1000, 1);
    vecs[16] = mk(1, 1, 2'd1, 4'hC, 4'h0, 4'h0, 4'h0, 4'h7, 4'b1000, 1);
    vecs[17] = mk(0, 0, 2'd1, 4'hC, 4'h0, 4'h0, 4'h0, 4'h7, 4'b1000, 1);
    vecs[18] = mk(0, 0, 2'd1, 4'hC, 4'h0, 4'h0, 4'h0, 4'h7, 4'b1000, 1);
    vecs[19] = mk(0, 0, 2'd1, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0);
    // clr held high: a new sweep starts on the first edge after busy falls.
    vecs[20] = mk(1, 0, 2'd0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h0, 4'b0001, 0);
    vecs[21] = mk(0, 1, 2'd0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'b0001, 1);
    vecs[22] = mk(0, 1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1);
    vecs[23] = mk(0, 1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1);
    vecs[24] = mk(0, 1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1);
    vecs[25] = mk(0, 1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0);
    vecs[26] = mk(0, 1, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1);
    vecs[27] = mk(1, 0, 2'd0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1);
    vecs[28] = mk(1, 0, 2'd0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1);
    vecs[29] = mk(1, 0, 2'd0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1);
    vecs[30] = mk(1, 0, 2'd0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 0);
    vecs[31] = mk(1, 0, 2'd0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'b0001, 0);

    // Power-up reset
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'd0, '0);
    tick();
    tick();
    chk_all("rst0", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].wr, vecs[i].clr, vecs[i].sel, vecs[i].din);
      tick();
      chk_all($sformatf("vec%0d", i), int'(vecs[i].ea), int'(vecs[i].eb),
              int'(vecs[i].ec), int'(vecs[i].ed), int'(vecs[i].ev), int'(vecs[i].ebusy));
    end

    // Asynchronous reset between edges must clear the outputs at once.
    drive(1'b1, 1'b0, 2'd2, 4'h6);
    tick();
    chk_all("pre_arst", 2, 0, 6, 0, 4'b0101, 0);
    drive(1'b0, 1'b0, 2'd0, '0);
    #2 reset = 1'b1;
    #1;
    chk_all("arst", 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;

    // Reset during a sweep (when idx = 2) aborts it.
    drive(1'b1, 1'b0, 2'd0, 4'h3); tick();
    drive(1'b1, 1'b0, 2'd1, 4'hA); tick();
    drive(1'b1, 1'b0, 2'd2, 4'h5); tick();
    drive(1'b1, 1'b0, 2'd3, 4'hF); tick();
    drive(1'b0, 1'b1, 2'd0, '0);   tick();
    drive(1'b0, 1'b0, 2'd0, '0);   tick();
    tick();
    chk_all("mid_sweep", 0, 0, 5, 15, 4'b1100, 1);
    #2 reset = 1'b1;
    #1;
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    drive(1'b1, 1'b0, 2'd0, 4'h1);
    tick();
    chk_all("post_rst_wr", 1, 0, 0, 0, 4'b0001, 0);

    // Randomized run against the behavioural model
    drive(1'b0, 1'b0, 2'd0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 3)), W'($urandom_range(0, 15)));
      tick();
      chk_all($sformatf("rnd%0d", n), m_reg[0], m_reg[1], m_reg[2], m_reg[3],
              {28'd0, m_val[3], m_val[2], m_val[1], m_val[0]},
              (sweep_left > 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1to4_reg.md
Name: demux_1to4_reg

Overview:
- Write-side counterpart of the CPU's 4-to-1 operand select: routes one WIDTH-bit data word into one of four holding registers (a, b, c, d) chosen by a 2-bit select.
- The registered outputs feed the read-side 4-to-1 select directly.
- Adds per-register valid flags and a sequential clear sweep, so the datapath can invalidate all four operands without a global reset.

Parameters:
- WIDTH, 4, data width of the input and of each holding register.
- RESET_VAL, 0, value loaded into each register by reset and by the clear sweep (WIDTH bits, zero-extended or truncated).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  write data.
- sel  input  2  destination: 0→a, 1→b, 2→c, 3→d.
- wr_en  input  1  write request, sampled on the rising edge of clk.
- clr  input  1  clear-sweep request, sampled on the rising edge of clk.
- a  output  WIDTH  holding register 0.
- b  output  WIDTH  holding register 1.
- c  output  WIDTH  holding register 2.
- d  output  WIDTH  holding register 3.
- valid  output  4  valid[i] = register i has been written since its last clear or reset (bit0=a … bit3=d).
- busy  output  1  clear sweep in progress; registered.
- wr_ready  output  1  equals ~busy; a write is accepted only when wr_ready=1.

Behaviour:
- Reset (asynchronous, immediate, independent of clk):
  - a, b, c, d = RESET_VAL; valid = 4'b0000; busy = 0; wr_ready = 1.
  - state = IDLE; sweep index = 0.
- Reset asserted mid-sweep aborts the sweep; after deassertion the block is IDLE.
- States: IDLE, CLEAR. Internal 2-bit sweep index idx.
- IDLE:
  - clr=1 at an edge → state CLEAR, idx=0, busy=1 after that edge. No register changes on that edge.
  - else wr_en=1 at an edge → register[sel] <= in and valid[sel] <= 1 on that edge. Latency is 1 cycle (value visible after the edge). The other three registers and flags hold.
  - wr_en=0 and clr=0 → all state holds.
  - clr=1 and wr_en=1 on the same edge → clr wins; the write is dropped and not deferred.
- CLEAR, at each edge:
  - register[idx] <= RESET_VAL, valid[idx] <= 0, idx <= idx+1.
  - On the edge where idx=3: state → IDLE, busy → 0, idx wraps to 0.
  - busy is high for exactly 4 cycles; registers clear in the order a, b, c, d.
  - Registers not yet swept keep their old value and valid flag during the sweep.
- During CLEAR, wr_en and clr are ignored. A new clr does not restart the sweep, and writes are not queued.
- The first edge with busy=0 accepts wr_en and clr again. A clr held high continuously therefore starts a new sweep immediately after the previous one ends.
- Repeated writes to the same sel overwrite the register; valid stays 1.
- in and sel are don't-care when wr_en=0 or busy=1.
- No combinational path from inputs to any output. wr_ready depends only on busy.

Test Plan:
- Reset: assert reset between edges → a..d=0, valid=0000, busy=0 immediately, without waiting for a clk edge.
- Writes: wr_en=1 with (sel,in) = (0,4'h3), (1,4'hA), (2,4'h5), (3,4'hF) on consecutive edges → after the 4th edge a=3, b=A, c=5, d=F, valid=1111. Each value appears exactly one edge after its request.
- Overwrite and hold: with wr_en=0 for 3 cycles → values unchanged. Then write sel=2 in=4'h9 → c=9, a/b/d unchanged, valid=1111.
- Clear sweep: from a=3, b=A, c=5, d=F, pulse clr for 1 cycle.
  - busy=1 for exactly 4 cycles.
  - After sweep edge 1: a=0, valid=1110. After edge 2: valid=1100. After edge 3: valid=1000. After edge 4: valid=0000, all registers 0, busy=0.
  - wr_en=1 sel=3 in=7 held during the sweep is dropped, so d=0. The same request on the first edge after busy falls writes d=7.
- Collision: clr=1 and wr_en=1 (sel=1, in=4'hC) on the same IDLE edge → sweep starts and b is never written with C.
- Reset mid-sweep: assert reset while busy=1 with idx=2 → immediately all registers 0, valid=0000, busy=0. After release, a write sel=0 in=1 on the next edge gives a=1.
